// File: rtl/fbdiv_if.sv
// Ratio handshake and divider outputs between the loop controller and fbdiv_ctrl.
interface fbdiv_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             ratio_req;
    logic [WIDTH-1:0] ratio_in;
    logic             ratio_ack;
    logic             ratio_err;
    logic             busy;
    logic             out;
    logic             period_tick;
    logic [WIDTH-1:0] ratio_cur;

    modport master (
        output en, ratio_req, ratio_in,
        input  ratio_ack, ratio_err, busy, out, period_tick, ratio_cur
    );

    modport slave (
        input  en, ratio_req, ratio_in,
        output ratio_ack, ratio_err, busy, out, period_tick, ratio_cur
    );
endinterface

// File: rtl/fbdiv_ctrl.sv
// PLL feedback divider: divides clk by a run-time ratio N, swapping ratios only
// at period boundaries so the PFD never sees a truncated or stretched period.
module fbdiv_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEFAULT_RATIO = 4
) (
    input logic   clk,
    input logic   rst,
    fbdiv_if.slave bus
);
    localparam int unsigned W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t       state, state_d;
    logic [W-1:0] cnt, cnt_d;
    logic [W-1:0] ratio_cur, ratio_cur_d;
    logic [W-1:0] pend, pend_d;
    logic         ack, ack_d;
    logic         err, err_d;
    logic         busy, busy_d;
    logic         out_q, out_d;
    logic         tick, tick_d;

    logic         sample_c;
    logic         valid_c;
    logic         wrap_c;
    logic         run_c;

    // A request is only looked at when no earlier one is pending or being answered.
    assign sample_c = bus.ratio_req && !busy && !ack && !err;
    assign valid_c  = bus.ratio_in >= W'(2);
    assign wrap_c   = cnt == (ratio_cur - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    state_d = RUN;
                RUN:     if (sample_c && valid_c) state_d = PEND;
                PEND:    if (wrap_c) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values for the counter, ratio bookkeeping and all registered outputs.
    always_comb begin
        cnt_d       = '0;
        ratio_cur_d = ratio_cur;
        pend_d      = pend;
        ack_d       = 1'b0;
        err_d       = sample_c && !valid_c;
        busy_d      = busy;
        run_c       = bus.en;

        if (!bus.en || state == IDLE) begin
            // Leaving or sitting in IDLE: pending ratio or a fresh request applies at once.
            if (state == PEND) begin
                ratio_cur_d = pend;
                ack_d       = 1'b1;
                busy_d      = 1'b0;
            end else if (sample_c && valid_c) begin
                ratio_cur_d = bus.ratio_in;
                ack_d       = 1'b1;
            end
        end else begin
            cnt_d = wrap_c ? '0 : cnt + W'(1);
            if (state == PEND && wrap_c) begin
                ratio_cur_d = pend;
                ack_d       = 1'b1;
                busy_d      = 1'b0;
            end
            if (state == RUN && sample_c && valid_c) begin
                pend_d = bus.ratio_in;
                busy_d = 1'b1;
            end
        end

        out_d  = run_c && (cnt_d >= (ratio_cur_d >> 1));
        tick_d = run_c && (cnt_d == (ratio_cur_d - W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ratio_cur <= W'(DEFAULT_RATIO);
            pend      <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            out_q     <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            ratio_cur <= ratio_cur_d;
            pend      <= pend_d;
            ack       <= ack_d;
            err       <= err_d;
            busy      <= busy_d;
            out_q     <= out_d;
            tick      <= tick_d;
        end
    end

    assign bus.ratio_ack   = ack;
    assign bus.ratio_err   = err;
    assign bus.busy        = busy;
    assign bus.out         = out_q;
    assign bus.period_tick = tick;
    assign bus.ratio_cur   = ratio_cur;
endmodule
